// File: rtl/ode_store_arbiter_pkg.sv
// Shared types for the ODE store arbiter: write-tag codes and queue entry layout.
package ode_store_arbiter_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        SEL_SRC2_BYP = 2'd0,
        SEL_SRC1_BYP = 2'd1,
        SEL_SRC2_Q   = 2'd2,
        SEL_SRC1_Q   = 2'd3
    } sel_t;

    // src = 1 marks a word from source 1
    typedef struct packed {
        logic              src;
        logic [WORD_W-1:0] word;
    } entry_t;

    function automatic sel_t make_sel(input logic from_src1, input logic from_queue);
        return sel_t'({from_queue, from_src1});
    endfunction

endpackage

// File: rtl/ode_store_arbiter_if.sv
// Producer-side store requests and memory write port of the store arbiter.
interface ode_store_arbiter_if;
    import ode_store_arbiter_pkg::*;

    logic              store1;
    logic              store2;
    logic [WORD_W-1:0] temp1;
    logic [WORD_W-1:0] temp2;
    logic              write;
    logic [WORD_W-1:0] data1;
    logic [WORD_W-1:0] data2;
    logic [1:0]        select;

    modport master (
        output store1, store2, temp1, temp2,
        input  write, data1, data2, select
    );

    modport slave (
        input  store1, store2, temp1, temp2,
        output write, data1, data2, select
    );

endinterface

// File: rtl/ode_store_arbiter_store_fifo.sv
// Two-push/one-pop FIFO of queue entries with an explicit occupancy count.
module store_fifo
    import ode_store_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pop,
    input  logic          push0,
    input  logic          push1,
    input  entry_t        push0_entry,
    input  entry_t        push1_entry,
    output logic [CW-1:0] count,
    output entry_t        head
);

    entry_t         mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;

    assign head = mem[rd_ptr];

    // push1 is only ever asserted together with push0, so it lands in the slot after push0
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push0) mem[wr_ptr] <= push0_entry;
            if (push1) mem[wr_ptr + AW'(1)] <= push1_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
            count  <= count - CW'(pop) + CW'(push0) + CW'(push1);
        end
    end

endmodule

// File: rtl/ode_store_arbiter.sv
// Serialises two producers' store words onto one memory write port, FIFO order,
// bypassing the queue when it is empty.
module ode_store_arbiter
    import ode_store_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input logic               clk,
    input logic               reset,
    ode_store_arbiter_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]     fifo_count;
    entry_t            fifo_head;
    logic              pop;
    logic              push0;
    logic              push1;
    entry_t            arr0;
    entry_t            arr1;
    entry_t            cand0;
    logic              cand0_v;
    logic              cand1_v;
    logic              issue;
    logic [WORD_W-1:0] issue_word;
    sel_t              issue_sel;
    logic [CW-1:0]     room;
    logic [CW-1:0]     next_count;

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .pop         (pop),
        .push0       (push0),
        .push1       (push1),
        .push0_entry (cand0),
        .push1_entry (arr1),
        .count       (fifo_count),
        .head        (fifo_head)
    );

    always_comb begin
        arr0       = bus.store1 ? entry_t'{src: 1'b1, word: bus.temp1}
                                : entry_t'{src: 1'b0, word: bus.temp2};
        arr1       = entry_t'{src: 1'b0, word: bus.temp2};
        pop        = 1'b0;
        issue      = 1'b0;
        issue_word = '0;
        issue_sel  = SEL_SRC2_BYP;
        cand0      = arr0;
        cand0_v    = 1'b0;
        cand1_v    = 1'b0;

        if (fifo_count != '0) begin
            pop        = 1'b1;
            issue      = 1'b1;
            issue_word = fifo_head.word;
            issue_sel  = make_sel(fifo_head.src, 1'b1);
            cand0_v    = bus.store1 | bus.store2;
            cand1_v    = bus.store1 & bus.store2;
        end else if (bus.store1 | bus.store2) begin
            // first arrival goes straight out; only a second arrival (always source 2) is queued
            issue      = 1'b1;
            issue_word = arr0.word;
            issue_sel  = make_sel(bus.store1, 1'b0);
            cand0      = arr1;
            cand0_v    = bus.store1 & bus.store2;
        end

        // room is measured after the pop; the later (source-2) candidate is the one dropped
        room       = CW'(DEPTH) - (fifo_count - CW'(pop));
        push0      = cand0_v && (room >= CW'(1));
        push1      = cand1_v && (room >= CW'(2));
        next_count = fifo_count - CW'(pop) + CW'(push0) + CW'(push1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.write  <= 1'b0;
            bus.data1  <= '0;
            bus.data2  <= '0;
            bus.select <= '0;
        end else begin
            bus.write  <= issue;
            bus.data1  <= issue_word;
            bus.data2  <= WORD_W'(next_count);
            bus.select <= issue_sel;
        end
    end

endmodule

// File: tb/tb_ode_store_arbiter.sv
// Self-checking bench for ode_store_arbiter: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_ode_store_arbiter;

    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    ode_store_arbiter_if bus ();

    ode_store_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          src1;
        logic [31:0] w;
    } mentry_t;

    mentry_t q [$];

    typedef struct {
        logic        r;
        logic        s1;
        logic        s2;
        logic [31:0] t1;
        logic [31:0] t2;
        logic        ew;
        logic [1:0]  esel;
        logic [31:0] ed1;
        logic [31:0] ed2;
    } vec_t;

    vec_t vecs [10];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    task automatic drive(input logic r, input logic s1, input logic s2,
                         input logic [31:0] t1, input logic [31:0] t2);
        reset      = r;
        bus.store1 = s1;
        bus.store2 = s2;
        bus.temp1  = t1;
        bus.temp2  = t2;
        @(posedge clk);
        #1;
    endtask

    // Reference: arrivals listed source 1 first; queue head wins, else first arrival
    // bypasses; the rest are appended while there is room.
    task automatic model_step(input logic r, input logic s1, input logic s2,
                              input logic [31:0] t1, input logic [31:0] t2,
                              output logic ew, output logic [1:0] esel,
                              output logic [31:0] ed1, output logic [31:0] ed2);
        mentry_t arr [$];
        mentry_t e;
        ew   = 1'b0;
        esel = 2'd0;
        ed1  = '0;
        ed2  = '0;
        if (r) begin
            q.delete();
            return;
        end
        if (s1) arr.push_back('{1'b1, t1});
        if (s2) arr.push_back('{1'b0, t2});
        if (q.size() > 0) begin
            e    = q.pop_front();
            ew   = 1'b1;
            esel = e.src1 ? 2'd3 : 2'd2;
            ed1  = e.w;
        end else if (arr.size() > 0) begin
            e    = arr.pop_front();
            ew   = 1'b1;
            esel = e.src1 ? 2'd1 : 2'd0;
            ed1  = e.w;
        end
        foreach (arr[i]) begin
            if (q.size() < DEPTH) q.push_back(arr[i]);
        end
        ed2 = 32'(q.size());
    endtask

    task automatic mstep(input string tag, input logic r, input logic s1, input logic s2,
                         input logic [31:0] t1, input logic [31:0] t2);
        logic        ew;
        logic [1:0]  esel;
        logic [31:0] ed1;
        logic [31:0] ed2;
        model_step(r, s1, s2, t1, t2, ew, esel, ed1, ed2);
        drive(r, s1, s2, t1, t2);
        check($sformatf("%s.write", tag),  32'(bus.write),  32'(ew));
        check($sformatf("%s.select", tag), 32'(bus.select), 32'(esel));
        check($sformatf("%s.data1", tag),  bus.data1, ed1);
        check($sformatf("%s.data2", tag),  bus.data2, ed2);
    endtask

    initial begin
        bus.store1 = 1'b0;
        bus.store2 = 1'b0;
        bus.temp1  = '0;
        bus.temp2  = '0;

        //           r     s1    s2    temp1         temp2         w     sel   data1         data2
        vecs[0] = '{1'b1, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 2'd0, 32'h0,        32'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_00A1, 32'h0,        1'b1, 2'd1, 32'h0000_00A1, 32'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 2'd0, 32'h0,        32'd0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'hAAAA_0000, 32'hBBBB_0000, 1'b1, 2'd1, 32'hAAAA_0000, 32'd1};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'hCCCC_0000, 32'hDDDD_0000, 1'b1, 2'd2, 32'hBBBB_0000, 32'd2};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 2'd3, 32'hCCCC_0000, 32'd1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 2'd2, 32'hDDDD_0000, 32'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 2'd0, 32'h0,        32'd0};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 32'h0,        32'hEEEE_EEEE, 1'b1, 2'd0, 32'hEEEE_EEEE, 32'd0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 2'd0, 32'h0,        32'd0};

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].s1, vecs[i].s2, vecs[i].t1, vecs[i].t2);
            check($sformatf("vec%0d.write", i),  32'(bus.write),  32'(vecs[i].ew));
            check($sformatf("vec%0d.select", i), 32'(bus.select), 32'(vecs[i].esel));
            check($sformatf("vec%0d.data1", i),  bus.data1, vecs[i].ed1);
            check($sformatf("vec%0d.data2", i),  bus.data2, vecs[i].ed2);
        end

        // Overflow: both sources every edge until the queue saturates, then drain
        mstep("ovf.rst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < DEPTH + 2; i++)
            mstep($sformatf("ovf.fill%0d", i), 1'b0, 1'b1, 1'b1, 32'h1000 + 32'(i), 32'h2000 + 32'(i));
        check("ovf.data2_sat", bus.data2, 32'(DEPTH));
        for (int i = 0; i < DEPTH + 1; i++)
            mstep($sformatf("ovf.drain%0d", i), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("ovf.drained_write", 32'(bus.write), 32'd0);

        // Mid-drain reset with three words queued
        for (int i = 0; i < 3; i++)
            mstep($sformatf("mdr.fill%0d", i), 1'b0, 1'b1, 1'b1, 32'h3000 + 32'(i), 32'h4000 + 32'(i));
        check("mdr.queued3", bus.data2, 32'd3);
        mstep("mdr.rst", 1'b1, 1'b1, 1'b1, 32'h5555, 32'h6666);
        check("mdr.rst_write", 32'(bus.write), 32'd0);
        check("mdr.rst_data2", bus.data2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            mstep($sformatf("mdr.idle%0d", i), 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            check($sformatf("mdr.no_stale%0d", i), 32'(bus.write), 32'd0);
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic r;
            logic s1;
            logic s2;
            r  = ($urandom_range(0, 49) == 0);
            s1 = ($urandom_range(0, 99) < 70);
            s2 = ($urandom_range(0, 99) < 70);
            mstep($sformatf("rnd%0d", i), r, s1, s2, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
